router_fsm_ctrl: RTL

Input-side packet controller for the 1x3 router. It sequences each incoming packet through header decode, payload load, FIFO-full stall, parity load and parity check. It drives the strobes that enable the register block's latches and the synchronizer's write-enable path. It sits between the packet source and the register/synchronizer/FIFO datapath, and it is the only block that decides when a byte is written.

---
 rtl/router_fsm_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/router_fsm_ctrl.sv
// Input-side packet controller for the 1x3 router: sequences header decode,
// payload load, full stall and parity handling, and strobes the datapath.
module router_fsm_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        WAIT_TILL_EMPTY    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] addr_q;
    logic       hdr_valid;
    logic       hdr_empty;
    logic       sel_empty;
    logic       sel_soft;

    always_comb begin
        hdr_valid = pkt_valid && (data_in != 2'd3);
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
        case (addr_q)
            2'd0:    begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
            2'd1:    begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
            2'd2:    begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
            default: begin sel_empty = 1'b0;         sel_soft = 1'b0;         end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE_ADDRESS:
                if (hdr_valid) state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:
                if (sel_empty) state_nxt = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
                state_nxt = LOAD_DATA;
            LOAD_DATA:
                if (fifo_full)       state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) state_nxt = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (parity_done)        state_nxt = DECODE_ADDRESS;
                else if (low_pkt_valid) state_nxt = LOAD_PARITY;
                else                    state_nxt = LOAD_DATA;
            LOAD_PARITY:
                state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
                state_nxt = DECODE_ADDRESS;
        endcase
        // The selected port's timeout overrides any normal transition.
        if (state != DECODE_ADDRESS && sel_soft)
            state_nxt = DECODE_ADDRESS;
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= DECODE_ADDRESS;
            addr_q        <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && hdr_valid)
                addr_q <= data_in;
            detect_add    <= (state_nxt == DECODE_ADDRESS);
            lfd_state     <= (state_nxt == LOAD_FIRST_DATA);
            ld_state      <= (state_nxt == LOAD_DATA);
            laf_state     <= (state_nxt == LOAD_AFTER_FULL);
            full_state    <= (state_nxt == FIFO_FULL_STATE);
            rst_int_reg   <= (state_nxt == CHECK_PARITY_ERROR);
            write_enb_reg <= (state_nxt == LOAD_DATA) || (state_nxt == LOAD_AFTER_FULL) ||
                             (state_nxt == LOAD_PARITY);
            busy          <= (state_nxt != DECODE_ADDRESS) && (state_nxt != LOAD_DATA);
        end
    end

endmodule
